// File: rtl/minaret_arb_pkg.sv
// Shared types and widths for the minaret memory arbiter.
package minaret_arb_pkg;
    localparam int XLEN  = 32;
    localparam int MASKW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;
endpackage

// File: rtl/minaret_arb_timer.sv
// Grant timeout counter for the minaret arbiter (used with MINARET_ARB_TIMEOUT_EN).
module minaret_arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic mem_ready,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is held at zero while idle, so every grant starts from zero.
    always_comb begin
        cnt_d = '0;
        if (busy && !mem_ready && !expired)
            cnt_d = cnt_q + CW'(1);
    end

    assign expired = busy && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/minaret_mem_arbiter.sv
// Shares one memory port between the minaret instruction and data ports.
// Optional grant timeout with bus error: define MINARET_ARB_TIMEOUT_EN.
module minaret_mem_arbiter
    import minaret_arb_pkg::*;
#(
    parameter int MAX_DSTREAK    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_valid,
    output logic             imem_ready,
    input  logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  imem_rdata,
    input  logic             dmem_valid,
    output logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_addr,
    input  logic [MASKW-1:0] dmem_wmask,
    input  logic [XLEN-1:0]  dmem_wdata,
    output logic [XLEN-1:0]  dmem_rdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  mem_addr,
    output logic [MASKW-1:0] mem_wmask,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             bus_err
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          timeout;

`ifdef MINARET_ARB_TIMEOUT_EN
    minaret_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (reset),
        .busy      (state_q != IDLE),
        .mem_ready (mem_ready),
        .expired   (timeout)
    );
`else
    // Without the timer a grant waits forever; the parameter is inert.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_wmask  = '0;
        mem_wdata  = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        bus_err    = 1'b0;
        case (state_q)
            IDLE: begin
                // Streak only moves on arbitration decisions; no fetch pending resets it.
                if (dmem_valid && (!imem_valid || streak_q < SW'(MAX_DSTREAK))) begin
                    state_d = GNT_D;
                    if (imem_valid && streak_q != SW'(MAX_DSTREAK))
                        streak_d = streak_q + SW'(1);
                end else if (imem_valid) begin
                    state_d = GNT_I;
                end
                if (!imem_valid || state_d == GNT_I)
                    streak_d = '0;
            end
            GNT_I: begin
                mem_valid = imem_valid;
                mem_addr  = imem_addr;
                if (!imem_valid) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_rdata;
                    state_d    = IDLE;
                end else if (timeout) begin
                    imem_ready = 1'b1;
                    bus_err    = 1'b1;
                    state_d    = IDLE;
                end
            end
            GNT_D: begin
                mem_valid = dmem_valid;
                mem_addr  = dmem_addr;
                mem_wmask = dmem_wmask;
                mem_wdata = dmem_wdata;
                if (!dmem_valid) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = mem_rdata;
                    state_d    = IDLE;
                end else if (timeout) begin
                    dmem_ready = 1'b1;
                    bus_err    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end
endmodule

// File: tb/tb_minaret_mem_arbiter.sv
// Directed bench for minaret_mem_arbiter with a cycle-level ownership model.
module tb_minaret_mem_arbiter;
    localparam int MAXD = 4;
    localparam int TO   = 8;
`ifdef MINARET_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        imem_valid = 1'b0, dmem_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
    logic [3:0]  dmem_wmask = '0;
    logic        imem_ready, dmem_ready, mem_valid, bus_err;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    int checks = 0, fails = 0;
    byte done_log[$];

    minaret_mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: who owns the port (0 nobody, 1 fetch, 2 data), how many data wins
    // in a row a waiting fetch has suffered, and how long the owner has waited.
    int own = 0, streak = 0, waited = 0;

    function automatic logic own_valid();
        return (own == 1) ? imem_valid : (own == 2) ? dmem_valid : 1'b0;
    endfunction
    function automatic logic exp_done();
        return own != 0 && own_valid() && mem_ready;
    endfunction
    function automatic logic timed_out();
        return TO_EN && own != 0 && own_valid() && !mem_ready && waited == TO;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            own <= 0; streak <= 0; waited <= 0;
        end else begin
            waited <= waited + 1;
            if (own == 0) begin
                waited <= 0;
                if (dmem_valid && (!imem_valid || streak < MAXD)) begin
                    own    <= 2;
                    streak <= imem_valid ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
                end else if (imem_valid) begin
                    own <= 1; streak <= 0;
                end else begin
                    streak <= 0;
                end
            end else if (!own_valid() || mem_ready || timed_out()) begin
                own <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, own_valid()});
        chk("mem_addr", mem_addr, own == 1 ? imem_addr : own == 2 ? dmem_addr : 32'h0);
        chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, (own == 2) ? dmem_wmask : 4'h0});
        chk("mem_wdata", mem_wdata, own == 2 ? dmem_wdata : 32'h0);
        chk("imem_ready", {31'b0, imem_ready}, {31'b0, own == 1 && (exp_done() || timed_out())});
        chk("imem_rdata", imem_rdata, (own == 1 && exp_done()) ? mem_rdata : 32'h0);
        chk("dmem_ready", {31'b0, dmem_ready}, {31'b0, own == 2 && (exp_done() || timed_out())});
        chk("dmem_rdata", dmem_rdata, (own == 2 && exp_done()) ? mem_rdata : 32'h0);
        chk("bus_err", {31'b0, bus_err}, {31'b0, timed_out()});
        if (imem_ready) done_log.push_back("I");
        if (dmem_ready) done_log.push_back("D");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        string exp_seq;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        cyc(2);
        reset = 1'b0;

        // Fetch only, memory answers one cycle after the request is presented.
        cyc(1);
        imem_valid = 1'b1; imem_addr = 32'h0000_0100;
        cyc(1);
        @(negedge clk);
        chk("a_mem_valid", {31'b0, mem_valid}, 32'h1);
        chk("a_iready_early", {31'b0, imem_ready}, 32'h0);
        cyc(1);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        chk("a_iready", {31'b0, imem_ready}, 32'h1);
        chk("a_irdata", imem_rdata, 32'h0000_0013);
        chk("a_wmask", {28'b0, mem_wmask}, 32'h0);
        chk("a_addr", mem_addr, 32'h0000_0100);
        cyc(1);
        imem_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("a_iready_after", {31'b0, imem_ready}, 32'h0);

        // Simultaneous requests: data store first, fetch after one idle cycle.
        cyc(1);
        imem_valid = 1'b1; imem_addr = 32'h0000_0104;
        dmem_valid = 1'b1; dmem_addr = 32'h0000_1000; dmem_wmask = 4'hF; dmem_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
        cyc(1);
        @(negedge clk);
        chk("b_daddr", mem_addr, 32'h0000_1000);
        chk("b_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("b_wmask", {28'b0, mem_wmask}, 32'hF);
        chk("b_dready", {31'b0, dmem_ready}, 32'h1);
        chk("b_iready", {31'b0, imem_ready}, 32'h0);
        cyc(1);
        dmem_valid = 1'b0; dmem_wmask = '0; dmem_wdata = '0;
        @(negedge clk);
        chk("b_idle_gap", {31'b0, mem_valid}, 32'h0);
        cyc(1);
        @(negedge clk);
        chk("b_iaddr", mem_addr, 32'h0000_0104);
        chk("b_iready", {31'b0, imem_ready}, 32'h1);
        chk("b_iwdata", mem_wdata, 32'h0);
        cyc(1);
        imem_valid = 1'b0; mem_ready = 1'b0;

        // Both held with an always-ready memory: four data grants, then one fetch.
        cyc(1);
        done_log.delete();
        imem_valid = 1'b1; imem_addr = 32'h0000_0200;
        dmem_valid = 1'b1; dmem_addr = 32'h0000_2000;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
        cyc(20);
        imem_valid = 1'b0; dmem_valid = 1'b0; mem_ready = 1'b0;
        exp_seq = "DDDDIDDDDI";
        chk("c_count", done_log.size(), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < done_log.size())
                chk($sformatf("c_order_%0d", i), {24'b0, done_log[i]}, {24'b0, exp_seq[i]});

        // Fetch valid withdrawn while granted: no ready, back to idle.
        cyc(1);
        imem_valid = 1'b1; imem_addr = 32'h0000_0300;
        cyc(1);
        cyc(1);
        imem_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("d_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("d_iready", {31'b0, imem_ready}, 32'h0);
        cyc(1);
        mem_ready = 1'b0;

        // Reset in the middle of a data grant clears outputs immediately.
        cyc(1);
        dmem_valid = 1'b1; dmem_addr = 32'h0000_3000;
        cyc(1);
        @(negedge clk);
        chk("e_granted", {31'b0, mem_valid}, 32'h1);
        #2 reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("e_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("e_dready", {31'b0, dmem_ready}, 32'h0);
        chk("e_bus_err", {31'b0, bus_err}, 32'h0);
        chk("e_mem_addr", mem_addr, 32'h0);
        cyc(1);
        reset = 1'b0; dmem_valid = 1'b0; mem_ready = 1'b0;
        cyc(1);

`ifdef MINARET_ARB_TIMEOUT_EN
        // Data read with a silent memory: timeout after TO waiting cycles.
        dmem_valid = 1'b1; dmem_addr = 32'h0000_4000; mem_rdata = 32'h0000_ABCD;
        cyc(1);
        for (int i = 0; i <= TO; i++) begin
            @(negedge clk);
            if (i < TO) chk("f_wait", {31'b0, dmem_ready}, 32'h0);
            else begin
                chk("f_dready", {31'b0, dmem_ready}, 32'h1);
                chk("f_drdata", dmem_rdata, 32'h0);
                chk("f_bus_err", {31'b0, bus_err}, 32'h1);
            end
            cyc(1);
        end
        dmem_valid = 1'b0;
        @(negedge clk);
        chk("f_err_pulse", {31'b0, bus_err}, 32'h0);
        cyc(1);

        // Memory answers on the timeout cycle itself: normal completion wins.
        dmem_valid = 1'b1;
        cyc(1);
        for (int i = 0; i <= TO; i++) begin
            if (i == TO) mem_ready = 1'b1;
            @(negedge clk);
            if (i == TO) begin
                chk("g_dready", {31'b0, dmem_ready}, 32'h1);
                chk("g_drdata", dmem_rdata, 32'h0000_ABCD);
                chk("g_bus_err", {31'b0, bus_err}, 32'h0);
            end
            cyc(1);
        end
        dmem_valid = 1'b0; mem_ready = 1'b0;
`else
        // No timeout: a silent memory keeps the data port waiting.
        dmem_valid = 1'b1; dmem_addr = 32'h0000_4000; mem_rdata = 32'h0000_ABCD;
        cyc(1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("f_wait", {31'b0, dmem_ready | bus_err}, 32'h0);
            cyc(1);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("f_late_done", dmem_rdata, 32'h0000_ABCD);
        cyc(1);
        dmem_valid = 1'b0; mem_ready = 1'b0;
`endif
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
